// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared definitions for the instruction-memory loader.
//   - state_t / ST_*  : loader FSM state encodings
//   - BYTES_PER_WORD  : stream bytes per instruction word
//   - csum_next()     : running XOR checksum update
package imem_loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_LEN0  = 3'd0;
    localparam state_t ST_LEN1  = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_CSUM  = 3'd3;
    localparam state_t ST_DONE  = 3'd4;
    localparam state_t ST_ERROR = 3'd5;

    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: collects little-endian bytes into 32-bit words.
//   i_clk, i_resetn  : clock, async active-low reset
//   i_clear          : restart assembly at byte 0
//   i_byte_valid     : accepted byte on i_byte
//   o_byte_idx       : position the next accepted byte will fill
//   o_word           : last completed word (held until the next one completes)
//   o_word_ready     : one-cycle pulse the cycle after the fourth byte
module word_assembler
    import imem_loader_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_clear,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_byte_idx,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

    logic [23:0] r_asm;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_word;
    logic        r_word_ready;

    // Byte shift-in; the completed word is captured separately so it stays stable while written.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_asm        <= 24'd0;
            r_byte_idx   <= 2'd0;
            r_word       <= 32'd0;
            r_word_ready <= 1'b0;
        end else begin
            r_word_ready <= 1'b0;
            if (i_clear) begin
                r_asm      <= 24'd0;
                r_byte_idx <= 2'd0;
            end else if (i_byte_valid) begin
                case (r_byte_idx)
                    2'd0:    r_asm[7:0]   <= i_byte;
                    2'd1:    r_asm[15:8]  <= i_byte;
                    2'd2:    r_asm[23:16] <= i_byte;
                    default: r_asm        <= r_asm;
                endcase
                if (r_byte_idx == LAST_IDX) begin
                    r_word       <= {i_byte, r_asm};
                    r_word_ready <= 1'b1;
                end else begin
                    r_word       <= r_word;
                end
                r_byte_idx <= r_byte_idx + 2'd1;
            end else begin
                r_byte_idx <= r_byte_idx;
            end
        end
    end

    assign o_byte_idx   = r_byte_idx;
    assign o_word       = r_word;
    assign o_word_ready = r_word_ready;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: writes a byte-streamed program image into instruction memory
// and holds the core in reset until the image and its XOR checksum are good.
// Stream: LEN lo, LEN hi (word count), 4*LEN data bytes LE, checksum byte.
//   i_clk, i_resetn          : clock, async active-low reset
//   i_in_valid/i_in_data     : byte stream, accepted when o_in_ready is high
//   i_reload                 : restart pulse, honoured only in DONE/ERROR
//   o_imem_we/addr/wdata     : instruction memory write port
//   o_cpu_resetn             : core reset, released only in DONE
//   o_done / o_error         : load status
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_resetn,
    input  logic        i_in_valid,
    input  logic [7:0]  i_in_data,
    output logic        o_in_ready,
    input  logic        i_reload,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_wdata,
    output logic        o_cpu_resetn,
    output logic        o_done,
    output logic        o_error
);

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t      r_state;
    logic        r_in_ready;
    logic [7:0]  r_len_lo;
    logic [15:0] r_len;
    logic [15:0] r_word_cnt;
    logic [31:0] r_addr;
    logic [7:0]  r_csum;
    logic        r_done;
    logic        r_error;
    logic        r_cpu_resetn;

    state_t      w_state_nxt;
    logic        w_ready_nxt;
    logic        w_xfer;
    logic [16:0] w_len;
    logic        w_asm_valid;
    logic        w_asm_clear;
    logic [1:0]  w_byte_idx;
    logic [31:0] w_word;
    logic        w_word_ready;
    logic        w_restart;

    assign w_xfer      = i_in_valid & r_in_ready;
    assign w_len       = {1'b0, i_in_data, r_len_lo};
    assign w_asm_valid = w_xfer && (r_state == ST_DATA);
    assign w_asm_clear = w_xfer && (r_state == ST_LEN1);
    assign w_restart   = i_reload && ((r_state == ST_DONE) || (r_state == ST_ERROR));

    word_assembler u_asm (
        .i_clk        (i_clk),
        .i_resetn     (i_resetn),
        .i_clear      (w_asm_clear),
        .i_byte_valid (w_asm_valid),
        .i_byte       (i_in_data),
        .o_byte_idx   (w_byte_idx),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LEN0: begin
                if (w_xfer) w_state_nxt = ST_LEN1;
                else        w_state_nxt = r_state;
            end
            ST_LEN1: begin
                if (!w_xfer)                 w_state_nxt = r_state;
                else if (w_len > DEPTH_L)    w_state_nxt = ST_ERROR;
                else if (w_len == 17'd0)     w_state_nxt = ST_CSUM;
                else                         w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                // Leave only once the final word's write strobe has been issued.
                if (w_word_ready && (r_word_cnt == (r_len - 16'd1))) w_state_nxt = ST_CSUM;
                else                                                 w_state_nxt = r_state;
            end
            ST_CSUM: begin
                if (!w_xfer)                 w_state_nxt = r_state;
                else if (i_in_data == r_csum) w_state_nxt = ST_DONE;
                else                         w_state_nxt = ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (i_reload) w_state_nxt = ST_LEN0;
                else          w_state_nxt = r_state;
            end
            default: w_state_nxt = ST_LEN0;
        endcase
    end

    // Ready for the next cycle; dropped for the write cycle that follows a fourth byte.
    always_comb begin
        w_ready_nxt = 1'b0;
        case (w_state_nxt)
            ST_LEN0, ST_LEN1, ST_CSUM: w_ready_nxt = 1'b1;
            ST_DATA: begin
                if (w_asm_valid && (w_byte_idx == 2'd3)) w_ready_nxt = 1'b0;
                else                                     w_ready_nxt = 1'b1;
            end
            default: w_ready_nxt = 1'b0;
        endcase
    end

    // FSM, length, counters, address, checksum and status registers.
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state      <= ST_LEN0;
            r_in_ready   <= 1'b0;
            r_len_lo     <= 8'd0;
            r_len        <= 16'd0;
            r_word_cnt   <= 16'd0;
            r_addr       <= BASE_ADDR;
            r_csum       <= 8'd0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_resetn <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_in_ready   <= w_ready_nxt;
            r_done       <= (w_state_nxt == ST_DONE);
            r_error      <= (w_state_nxt == ST_ERROR);
            // Released one cycle after DONE is entered; dropped as soon as reload leaves DONE.
            r_cpu_resetn <= (r_state == ST_DONE) && (w_state_nxt == ST_DONE);
            if (w_xfer && (r_state == ST_LEN0)) begin
                r_len_lo <= i_in_data;
            end else begin
                r_len_lo <= r_len_lo;
            end
            if (w_asm_clear || w_restart) begin
                r_len      <= w_asm_clear ? w_len[15:0] : 16'd0;
                r_word_cnt <= 16'd0;
                r_addr     <= BASE_ADDR;
                r_csum     <= 8'd0;
            end else begin
                if (w_word_ready) begin
                    r_word_cnt <= r_word_cnt + 16'd1;
                    r_addr     <= r_addr + 32'd4;
                end else begin
                    r_word_cnt <= r_word_cnt;
                    r_addr     <= r_addr;
                end
                if (w_asm_valid) r_csum <= csum_next(r_csum, i_in_data);
                else             r_csum <= r_csum;
            end
        end
    end

    assign o_in_ready   = r_in_ready;
    assign o_imem_we    = w_word_ready;
    assign o_imem_addr  = r_addr;
    assign o_imem_wdata = w_word;
    assign o_cpu_resetn = r_cpu_resetn;
    assign o_done       = r_done;
    assign o_error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Expected writes are queued
// as each word is streamed and checked whenever the DUT strobes imem_we.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_resetn;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int writes_seen = 0;
    logic [63:0] exp_q[$];
    logic [31:0] img [0:299];

    imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .i_clk        (clk),
        .i_resetn     (resetn),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .i_reload     (reload),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_resetn (cpu_resetn),
        .o_done       (done),
        .o_error      (error)
    );

    always #5 clk = ~clk;

    // One clock; sample just after the edge and score any write strobe.
    task automatic cycle();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (imem_we === 1'b1) begin
            writes_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             imem_addr, imem_wdata, e[63:32], e[31:0]);
                end
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_during_write: got in_ready=%b, expected 0", in_ready);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int gap;
        int waited;
        gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) cycle();
        in_valid = 1'b1;
        in_data  = b;
        waited   = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            cycle();
            waited++;
        end
        if (waited >= 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stayed %b for byte %h, expected 1", in_ready, b);
        end
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic send_image(input int n, input bit bad_csum, input int gap);
        logic [7:0]  cs;
        logic [15:0] len;
        logic [31:0] w;
        cs  = 8'd0;
        len = 16'(n);
        send_byte(len[7:0], gap);
        send_byte(len[15:8], gap);
        for (int i = 0; i < n; i++) begin
            w = img[i];
            exp_q.push_back({BASE + 32'(4 * i), w});
            for (int b = 0; b < 4; b++) begin
                cs = cs ^ w[8*b +: 8];
                send_byte(w[8*b +: 8], gap);
            end
        end
        send_byte(bad_csum ? (cs ^ 8'h01) : cs, gap);
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        in_valid = 1'b0;
        reload   = 1'b0;
        exp_q.delete();
        repeat (2) cycle();
        resetn = 1'b1;
        cycle();
    endtask

    task automatic check_status(input string name, input logic d, input logic e, input logic c);
        checks++;
        if ({done, error, cpu_resetn} !== {d, e, c}) begin
            errors++;
            $display("FAIL %s: got done=%b error=%b cpu_resetn=%b, expected %b %b %b",
                     name, done, error, cpu_resetn, d, e, c);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({in_ready, imem_we, imem_addr, imem_wdata, cpu_resetn, done, error} !==
            {1'b0, 1'b0, BASE, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h wdata=%h cpu=%b done=%b err=%b, expected all reset values",
                     name, in_ready, imem_we, imem_addr, imem_wdata, cpu_resetn, done, error);
        end
    endtask

    task automatic check_drained(input string name, input int writes_exp, input int w0);
        checks++;
        if (exp_q.size() != 0 || (writes_seen - w0) != writes_exp) begin
            errors++;
            $display("FAIL %s: got %0d writes (%0d pending), expected %0d", name,
                     writes_seen - w0, exp_q.size(), writes_exp);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #2;
        check_reset_values("reset_values");
        do_reset();
    endtask

    task automatic test_single_word();
        int w0 = writes_seen;
        img[0] = 32'h00A0_0513;
        send_image(1, 1'b0, 0);
        check_status("single_done_edge", 1'b1, 1'b0, 1'b0);
        cycle();
        check_status("single_cpu_release", 1'b1, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_ready: got in_ready=%b, expected 0", in_ready);
        end
        check_drained("single_writes", 1, w0);
        reload = 1'b1;
        cycle();
        reload = 1'b0;
        check_status("done_reload", 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps();
        int w0;
        do_reset();
        w0 = writes_seen;
        img[0] = 32'hDEAD_BEEF;
        img[1] = 32'h1234_5678;
        send_image(2, 1'b0, 3);
        repeat (3) cycle();
        check_status("gaps_done", 1'b1, 1'b0, 1'b1);
        check_drained("gaps_writes", 2, w0);
    endtask

    task automatic test_zero_len();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_image(0, 1'b0, 0);
        cycle();
        check_status("zero_good", 1'b1, 1'b0, 1'b1);
        check_drained("zero_good_writes", 0, w0);
        do_reset();
        send_image(0, 1'b1, 0);
        repeat (3) cycle();
        check_status("zero_bad", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        int w0;
        do_reset();
        w0 = writes_seen;
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        check_status("overflow_err", 1'b0, 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL overflow_ready: got in_ready=%b, expected 0", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (6) cycle();
        in_valid = 1'b0;
        check_drained("overflow_writes", 0, w0);
    endtask

    task automatic test_full_depth();
        int w0;
        do_reset();
        w0 = writes_seen;
        for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
        img[DEPTH-1] = 32'hCAFE_F00D;
        send_image(DEPTH, 1'b0, 0);
        cycle();
        check_status("full_done", 1'b1, 1'b0, 1'b1);
        check_drained("full_writes", DEPTH, w0);
    endtask

    task automatic test_bad_csum_reload();
        int w0;
        do_reset();
        w0 = writes_seen;
        img[0] = 32'h0badc0de;
        send_image(1, 1'b1, 0);
        repeat (2) cycle();
        check_status("badcs_err", 1'b0, 1'b1, 1'b0);
        check_drained("badcs_writes", 1, w0);
        reload = 1'b1;
        cycle();
        reload = 1'b0;
        check_status("badcs_reload", 1'b0, 1'b0, 1'b0);
        w0 = writes_seen;
        img[0] = 32'hA5A5_0F0F;
        img[1] = 32'h0000_0001;
        send_image(2, 1'b0, 1);
        cycle();
        check_status("reload_done", 1'b1, 1'b0, 1'b1);
        check_drained("reload_writes", 2, w0);
    endtask

    task automatic test_mid_reset();
        int w0;
        do_reset();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        resetn = 1'b0;
        #1;
        check_reset_values("midreset_values");
        cycle();
        resetn = 1'b1;
        w0 = writes_seen;
        img[0] = 32'h7766_5544;
        send_image(1, 1'b0, 0);
        cycle();
        check_status("midreset_reload_done", 1'b1, 1'b0, 1'b1);
        check_drained("midreset_writes", 1, w0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_gaps();
        test_zero_len();
        test_overflow();
        test_full_depth();
        test_bad_csum_reload();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
